// File: rtl/boundary_scroll_ctrl.sv
// Scroll sequencer for the boundary memory: each vblank rising edge starts a burst of
// `speed` shift toggles spaced GAP+1 cycles apart, each presenting a row popped from a small FIFO.
module boundary_scroll_ctrl #(
  parameter int ROWS       = 480,
  parameter int DATA_W     = 40,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP        = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vblank,
  input  logic [2:0]        speed,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clr_flags,
  output logic              shift,
  output logic [DATA_W-1:0] mem_data,
  output logic [8:0]        scroll_count,
  output logic              busy,
  output logic              underflow,
  output logic              overrun
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [2:0]          remaining_q, remaining_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                vblank_prev_q, vblank_prev_d;
  logic                shift_q, shift_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic [8:0]          scroll_count_q, scroll_count_d;
  logic                underflow_q, underflow_d;
  logic                overrun_q, overrun_d;
  logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                wr_ready_q, wr_ready_d;

  logic vb_rise;
  logic push;
  logic pop;
  logic underflow_set;
  logic overrun_set;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      remaining_q    <= '0;
      gap_cnt_q      <= '0;
      vblank_prev_q  <= vblank;
      shift_q        <= 1'b0;
      mem_data_q     <= '0;
      scroll_count_q <= '0;
      underflow_q    <= 1'b0;
      overrun_q      <= 1'b0;
      fifo_mem_q     <= '{default: '0};
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      wr_ready_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      gap_cnt_q      <= gap_cnt_d;
      vblank_prev_q  <= vblank_prev_d;
      shift_q        <= shift_d;
      mem_data_q     <= mem_data_d;
      scroll_count_q <= scroll_count_d;
      underflow_q    <= underflow_d;
      overrun_q      <= overrun_d;
      fifo_mem_q     <= fifo_mem_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      wr_ready_q     <= wr_ready_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    gap_cnt_d      = gap_cnt_q;
    vblank_prev_d  = vblank;
    shift_d        = shift_q;
    mem_data_d     = mem_data_q;
    scroll_count_d = scroll_count_q;
    fifo_mem_d     = fifo_mem_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    pop            = 1'b0;
    underflow_set  = 1'b0;
    vb_rise        = vblank & ~vblank_prev_q;
    push           = wr_valid & wr_ready_q;
    overrun_set    = vb_rise & (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (vb_rise) begin
          remaining_d = speed;
          if (speed != 3'd0) state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        shift_d = ~shift_q;
        // Empty FIFO repeats the previous row rather than stalling the burst
        if (count_q != '0) begin
          pop        = 1'b1;
          mem_data_d = fifo_mem_q[rd_ptr_q];
        end else begin
          underflow_set = 1'b1;
        end
        scroll_count_d = (scroll_count_q == 9'(ROWS - 1)) ? 9'd0 : scroll_count_q + 9'd1;
        remaining_d    = remaining_q - 3'd1;
        gap_cnt_d      = GAP_W'(GAP);
        state_d        = S_GAP;
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d = (remaining_q != 3'd0) ? S_ISSUE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      fifo_mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    wr_ready_d  = (count_d != CNT_W'(FIFO_DEPTH));
    underflow_d = (underflow_q & ~clr_flags) | underflow_set;
    overrun_d   = (overrun_q & ~clr_flags) | overrun_set;
  end

  assign wr_ready     = wr_ready_q;
  assign shift        = shift_q;
  assign mem_data     = mem_data_q;
  assign scroll_count = scroll_count_q;
  assign busy         = (state_q != S_IDLE);
  assign underflow    = underflow_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_boundary_scroll_ctrl.sv
// Self-checking bench for boundary_scroll_ctrl: directed vector table, corner-case sequences,
// and random stimulus against a timeline-based reference model.
module tb_boundary_scroll_ctrl;

  localparam int ROWS       = 480;
  localparam int DATA_W     = 40;
  localparam int FIFO_DEPTH = 4;
  localparam int GAP        = 3;
  localparam int STEP       = GAP + 1;

  logic              clk;
  logic              reset;
  logic              vblank;
  logic [2:0]        speed;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              clr_flags;
  logic              shift;
  logic [DATA_W-1:0] mem_data;
  logic [8:0]        scroll_count;
  logic              busy;
  logic              underflow;
  logic              overrun;

  boundary_scroll_ctrl #(
    .ROWS(ROWS), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .GAP(GAP)
  ) dut (
    .clk(clk), .reset(reset), .vblank(vblank), .speed(speed),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_flags(clr_flags), .shift(shift), .mem_data(mem_data),
    .scroll_count(scroll_count), .busy(busy), .underflow(underflow), .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a burst is a start cycle plus a row count; steps happen at fixed offsets.
  int                m_cyc = 0;
  int                m_t = 0;
  int                m_n = 0;
  bit                m_in_burst = 0;
  logic              m_shift = 0;
  logic [DATA_W-1:0] m_mem = '0;
  int                m_sc = 0;
  logic              m_uf = 0;
  logic              m_ov = 0;
  logic              m_ready = 1;
  logic              m_vbprev = 0;
  logic [DATA_W-1:0] m_fifo[$];

  logic [8:0]        scroll_log[$];
  logic [DATA_W-1:0] mem_log[$];

  typedef struct {
    logic              rst_n;
    logic              vb;
    logic [2:0]        spd;
    logic              wv;
    logic [DATA_W-1:0] wd;
    logic              clr;
    logic              e_shift;
    logic [DATA_W-1:0] e_mem;
    int                e_sc;
    logic              e_busy;
    logic              e_uf;
    logic              e_ov;
    logic              e_ready;
  } vec_t;

  vec_t vecs[16];

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, m_cyc);
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic vb, input logic [2:0] spd,
                               input logic wv, input logic [DATA_W-1:0] wd, input logic clr);
    reset     = rst_n;
    vblank    = vb;
    speed     = spd;
    wr_valid  = wv;
    wr_data   = wd;
    clr_flags = clr;
  endtask

  task automatic model_step();
    bit busy_pre;
    bit issue;
    bit ready_pre;
    bit uf_set;
    bit ov_set;
    m_cyc++;
    if (!reset) begin
      m_in_burst = 0;
      m_shift    = 0;
      m_mem      = '0;
      m_sc       = 0;
      m_uf       = 0;
      m_ov       = 0;
      m_ready    = 1;
      m_fifo.delete();
    end else begin
      uf_set    = 0;
      ov_set    = 0;
      ready_pre = m_ready;
      busy_pre  = m_in_burst && (m_cyc > m_t) && (m_cyc <= m_t + STEP * m_n);
      issue     = busy_pre && (((m_cyc - m_t - 1) % STEP) == 0);
      if (issue) begin
        m_shift = ~m_shift;
        if (m_fifo.size() > 0) m_mem = m_fifo.pop_front();
        else uf_set = 1;
        m_sc = (m_sc + 1) % ROWS;
      end
      if (wr_valid && ready_pre) m_fifo.push_back(wr_data);
      if (vblank && !m_vbprev) begin
        if (busy_pre) ov_set = 1;
        else if (speed != 0) begin
          m_in_burst = 1;
          m_t        = m_cyc;
          m_n        = int'(speed);
        end
      end
      if (clr_flags) begin
        m_uf = 0;
        m_ov = 0;
      end
      if (uf_set) m_uf = 1;
      if (ov_set) m_ov = 1;
      m_ready = (m_fifo.size() < FIFO_DEPTH);
    end
    m_vbprev = vblank;
  endtask

  task automatic checkOutput();
    bit m_busy;
    m_busy = m_in_burst && (m_cyc >= m_t) && (m_cyc < m_t + STEP * m_n);
    check_val("model_shift",     64'(shift),        64'(m_shift));
    check_val("model_mem_data",  64'(mem_data),     64'(m_mem));
    check_val("model_scroll",    64'(scroll_count), 64'(m_sc));
    check_val("model_busy",      64'(busy),         64'(m_busy));
    check_val("model_underflow", 64'(underflow),    64'(m_uf));
    check_val("model_overrun",   64'(overrun),      64'(m_ov));
    check_val("model_wr_ready",  64'(wr_ready),     64'(m_ready));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    checkOutput();
  endtask

  // One vblank pulse, then enough cycles for the whole burst; logs rows and counts at each toggle.
  task automatic run_burst(input logic [2:0] spd, input int again_at, output int toggles);
    logic prev;
    toggles = 0;
    prev    = shift;
    applyStimulus(1, 1, spd, 0, '0, 0);
    tick();
    if (shift !== prev) toggles++;
    prev = shift;
    for (int i = 1; i <= STEP * int'(spd) + STEP; i++) begin
      applyStimulus(1, (i == again_at), 3'd0, 0, '0, 0);
      tick();
      if (shift !== prev) begin
        toggles++;
        scroll_log.push_back(scroll_count);
        mem_log.push_back(mem_data);
      end
      prev = shift;
    end
    applyStimulus(1, 0, 3'd0, 0, '0, 0);
    check_val("burst_idle_after", 64'(busy), 64'd0);
  endtask

  initial begin
    int                toggles;
    int                guard;
    int                n;
    logic              prev;
    logic [DATA_W-1:0] words[5];

    vecs[0]  = '{1, 0, 3'd0, 1, 40'hA1, 0,  0, 40'h00, 0, 0, 0, 0, 1};
    vecs[1]  = '{1, 0, 3'd0, 1, 40'hB2, 0,  0, 40'h00, 0, 0, 0, 0, 1};
    vecs[2]  = '{1, 0, 3'd0, 1, 40'hC3, 0,  0, 40'h00, 0, 0, 0, 0, 1};
    vecs[3]  = '{1, 1, 3'd3, 0, 40'h00, 0,  0, 40'h00, 0, 1, 0, 0, 1};
    vecs[4]  = '{1, 0, 3'd0, 0, 40'h00, 0,  1, 40'hA1, 1, 1, 0, 0, 1};
    vecs[5]  = '{1, 0, 3'd0, 0, 40'h00, 0,  1, 40'hA1, 1, 1, 0, 0, 1};
    vecs[6]  = '{1, 0, 3'd0, 0, 40'h00, 0,  1, 40'hA1, 1, 1, 0, 0, 1};
    vecs[7]  = '{1, 0, 3'd0, 0, 40'h00, 0,  1, 40'hA1, 1, 1, 0, 0, 1};
    vecs[8]  = '{1, 0, 3'd0, 0, 40'h00, 0,  0, 40'hB2, 2, 1, 0, 0, 1};
    vecs[9]  = '{1, 0, 3'd0, 0, 40'h00, 0,  0, 40'hB2, 2, 1, 0, 0, 1};
    vecs[10] = '{1, 0, 3'd0, 0, 40'h00, 0,  0, 40'hB2, 2, 1, 0, 0, 1};
    vecs[11] = '{1, 0, 3'd0, 0, 40'h00, 0,  0, 40'hB2, 2, 1, 0, 0, 1};
    vecs[12] = '{1, 0, 3'd0, 0, 40'h00, 0,  1, 40'hC3, 3, 1, 0, 0, 1};
    vecs[13] = '{1, 0, 3'd0, 0, 40'h00, 0,  1, 40'hC3, 3, 1, 0, 0, 1};
    vecs[14] = '{1, 0, 3'd0, 0, 40'h00, 0,  1, 40'hC3, 3, 1, 0, 0, 1};
    vecs[15] = '{1, 0, 3'd0, 0, 40'h00, 0,  1, 40'hC3, 3, 0, 0, 0, 1};

    words[0] = 40'h11_1111_1111;
    words[1] = 40'h22_2222_2222;
    words[2] = 40'h33_3333_3333;
    words[3] = 40'h44_4444_4444;
    words[4] = 40'h55_5555_5555;

    $display("[TB] reset with vblank held high");
    applyStimulus(0, 1, 3'd0, 0, '0, 0);
    tick();
    tick();
    check_val("rst_shift",     64'(shift),        64'd0);
    check_val("rst_mem_data",  64'(mem_data),     64'd0);
    check_val("rst_scroll",    64'(scroll_count), 64'd0);
    check_val("rst_busy",      64'(busy),         64'd0);
    check_val("rst_underflow", 64'(underflow),    64'd0);
    check_val("rst_overrun",   64'(overrun),      64'd0);
    check_val("rst_wr_ready",  64'(wr_ready),     64'd1);
    applyStimulus(1, 1, 3'd5, 0, '0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("release_no_burst", 64'(busy), 64'd0);
    end
    applyStimulus(1, 0, 3'd0, 0, '0, 0);
    tick();

    $display("[TB] normal burst vector table");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].vb, vecs[i].spd, vecs[i].wv, vecs[i].wd, vecs[i].clr);
      tick();
      check_val($sformatf("vec%0d_shift", i),     64'(shift),        64'(vecs[i].e_shift));
      check_val($sformatf("vec%0d_mem_data", i),  64'(mem_data),     64'(vecs[i].e_mem));
      check_val($sformatf("vec%0d_scroll", i),    64'(scroll_count), 64'(vecs[i].e_sc));
      check_val($sformatf("vec%0d_busy", i),      64'(busy),         64'(vecs[i].e_busy));
      check_val($sformatf("vec%0d_underflow", i), 64'(underflow),    64'(vecs[i].e_uf));
      check_val($sformatf("vec%0d_overrun", i),   64'(overrun),      64'(vecs[i].e_ov));
      check_val($sformatf("vec%0d_wr_ready", i),  64'(wr_ready),     64'(vecs[i].e_ready));
    end

    $display("[TB] underflow burst");
    applyStimulus(1, 0, 3'd0, 1, 40'h55, 0);
    tick();
    mem_log.delete();
    run_burst(3'd2, -1, toggles);
    check_val("uf_toggles", 64'(toggles), 64'd2);
    check_val("uf_log_size", 64'(mem_log.size()), 64'd2);
    if (mem_log.size() == 2) begin
      check_val("uf_row0", 64'(mem_log[0]), 64'h55);
      check_val("uf_row1", 64'(mem_log[1]), 64'h55);
    end
    check_val("uf_flag_set", 64'(underflow), 64'd1);
    applyStimulus(1, 0, 3'd0, 0, '0, 1);
    tick();
    check_val("uf_flag_clr", 64'(underflow), 64'd0);
    applyStimulus(1, 0, 3'd0, 0, '0, 0);

    $display("[TB] fifo full");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 0, 3'd0, 1, words[k], 0);
      tick();
      if (k == 3) check_val("full_after_4th", 64'(wr_ready), 64'd0);
      if (k == 4) check_val("full_5th_held", 64'(wr_ready), 64'd0);
    end
    prev = shift;
    applyStimulus(1, 1, 3'd1, 1, words[4], 0);
    tick();
    check_val("full_edge_ready", 64'(wr_ready), 64'd0);
    applyStimulus(1, 0, 3'd0, 1, words[4], 0);
    tick();
    check_val("full_pop_toggle", 64'(shift != prev), 64'd1);
    check_val("full_pop_word1", 64'(mem_data), 64'(words[0]));
    check_val("full_ready_back", 64'(wr_ready), 64'd1);
    tick();
    applyStimulus(1, 0, 3'd0, 0, '0, 0);
    tick();
    tick();
    check_val("full_burst_done", 64'(busy), 64'd0);

    $display("[TB] overrun");
    run_burst(3'd4, 6, toggles);
    check_val("ov_toggles", 64'(toggles), 64'd4);
    check_val("ov_flag_set", 64'(overrun), 64'd1);
    applyStimulus(1, 0, 3'd0, 0, '0, 1);
    tick();
    check_val("ov_flag_clr", 64'(overrun), 64'd0);
    applyStimulus(1, 0, 3'd0, 0, '0, 0);

    $display("[TB] scroll wrap");
    guard = 0;
    while (m_sc != ROWS - 2 && guard < 200) begin
      n = ROWS - 2 - m_sc;
      if (n > 7) n = 7;
      run_burst(3'(n), -1, toggles);
      guard++;
    end
    check_val("wrap_preload", 64'(scroll_count), 64'(ROWS - 2));
    scroll_log.delete();
    run_burst(3'd3, -1, toggles);
    check_val("wrap_toggles", 64'(toggles), 64'd3);
    check_val("wrap_log_size", 64'(scroll_log.size()), 64'd3);
    if (scroll_log.size() == 3) begin
      check_val("wrap_step0", 64'(scroll_log[0]), 64'd479);
      check_val("wrap_step1", 64'(scroll_log[1]), 64'd0);
      check_val("wrap_step2", 64'(scroll_log[2]), 64'd1);
    end

    $display("[TB] reset mid-burst");
    toggles = 0;
    prev    = shift;
    applyStimulus(1, 1, 3'd5, 0, '0, 0);
    tick();
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1, 0, 3'd0, 0, '0, 0);
      tick();
      if (shift !== prev) toggles++;
      prev = shift;
    end
    check_val("mid_toggles_before_reset", 64'(toggles), 64'd2);
    applyStimulus(0, 0, 3'd0, 0, '0, 0);
    tick();
    check_val("mid_reset_shift", 64'(shift), 64'd0);
    check_val("mid_reset_busy",  64'(busy),  64'd0);
    applyStimulus(1, 0, 3'd0, 0, '0, 0);
    for (int i = 0; i < 24; i++) begin
      tick();
      check_val("mid_reset_quiet", 64'(shift), 64'd0);
    end

    $display("[TB] random stimulus");
    begin
      logic vb_r;
      vb_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 9) == 0) vb_r = ~vb_r;
        applyStimulus(($urandom_range(0, 299) != 0), vb_r, 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), {8'($urandom()), $urandom()},
                      ($urandom_range(0, 29) == 0));
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
